// File: rtl/sort_pkg.sv
// -----------------------------------------------------------------------------
// sort_pkg
// Shared types and helpers for the insertion-sort buffer and its compare slice.
//   sort_state_t : FSM state encoding, Gray-coded (000,001,011,010,110,111)
//   sort_dir_t   : sort direction, ASC=0 / DESC=1
//   sort_aw()    : address width helper for a given DEPTH
// -----------------------------------------------------------------------------
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    CLEAR  = 3'b001,
    J_LOAD = 3'b011,
    SCAN   = 3'b010,
    WRITE  = 3'b110,
    DONE   = 3'b111
  } sort_state_t;

  typedef enum logic {
    ASC  = 1'b0,
    DESC = 1'b1
  } sort_dir_t;

  // Address width for a storage of 'depth' words (never narrower than 1 bit).
  function automatic int sort_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sort_cmp.sv
// -----------------------------------------------------------------------------
// sort_cmp
// Combinational ordering test used by the insertion sort (and the merge stage).
// Strict compare, so equal words are never moved past each other (stable sort).
//   i_a      : word already in the sorted prefix
//   i_key    : word being inserted
//   i_dir    : 0 = ascending, 1 = descending
//   o_before : 1 when i_a must move up one slot to make room for i_key
// -----------------------------------------------------------------------------
module sort_cmp
  import sort_pkg::*;
#(
  parameter int W      = 16,
  parameter int SIGNED = 0
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_key,
  input  logic         i_dir,
  output logic         o_before
);

  logic w_gt;
  logic w_lt;

  always_comb begin
    if (SIGNED != 0) begin
      w_gt = $signed(i_a) > $signed(i_key);
      w_lt = $signed(i_a) < $signed(i_key);
    end else begin
      w_gt = i_a > i_key;
      w_lt = i_a < i_key;
    end
    o_before = (sort_dir_t'(i_dir) == DESC) ? w_lt : w_gt;
  end

endmodule

// File: rtl/sort_buffer.sv
// -----------------------------------------------------------------------------
// sort_buffer
// LIFO-addressed register store of DEPTH words of W bits that can be sorted in
// place (insertion sort), ascending or descending, signed or unsigned.
//   clk, rstn        : clock (rising edge), asynchronous active-low reset
//   enable           : clock enable, freezes all state when low
//   push/pop/clear/sort : single-cycle strobes, accepted only while idle
//   descend          : direction, sampled together with sort
//   din              : push data
//   dout, dout_valid : last popped word and its one-cycle valid pulse
//   count, full, empty : occupancy
//   idle, done, err  : FSM idle, sort-complete pulse, overflow/underflow pulse
// -----------------------------------------------------------------------------
module sort_buffer
  import sort_pkg::*;
#(
  parameter int  W      = 16,
  parameter int  DEPTH  = 256,
  parameter int  SIGNED = 0,
  localparam int AW     = sort_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic          sort,
  input  logic          descend,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          idle,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_TWO  = (AW+1)'(2);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW-1:0] IDX_ZERO = '0;

  sort_state_t   r_state;
  sort_state_t   w_next_state;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW:0]   r_count;
  logic [AW-1:0] r_j;
  logic [AW-1:0] r_i;
  logic [W-1:0]  r_key;
  logic          r_dir;
  logic          r_below;
  logic [W-1:0]  r_dout;
  logic          r_dout_valid;
  logic          r_done;
  logic          r_err;

  logic          w_full;
  logic          w_empty;
  logic          w_before;
  logic          w_last_j;
  logic [AW-1:0] w_top_idx;
  logic [AW-1:0] w_shift_idx;
  logic [W-1:0]  w_top_word;
  logic [W-1:0]  w_j_word;
  logic [W-1:0]  w_i_word;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [W-1:0]  w_wdata;
  logic          w_do_clear;
  logic          w_do_push;
  logic          w_do_pop;
  logic          w_do_sort;

  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  // Low AW bits of count minus one wrap correctly to DEPTH-1 when full.
  assign w_top_idx   = r_count[AW-1:0] - IDX_ONE;
  assign w_shift_idx = r_i + IDX_ONE;
  assign w_last_j    = (({1'b0, r_j} + CNT_ONE) == r_count);
  assign w_top_word  = r_mem[w_top_idx];
  assign w_j_word    = r_mem[r_j];
  assign w_i_word    = r_mem[r_i];

  sort_cmp #(
    .W      (W),
    .SIGNED (SIGNED)
  ) u_cmp (
    .i_a      (w_i_word),
    .i_key    (r_key),
    .i_dir    (r_dir),
    .o_before (w_before)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else if (enable) begin
      r_state <= w_next_state;
    end
  end

  // Strobe decode (IDLE only, clear > push > pop > sort), next state and the
  // single write port. CLEAR is part of the shared encoding but the buffer
  // clears straight from IDLE, so it is never entered here.
  // When the last shift lands at A[0] the FSM spends one more SCAN cycle
  // with r_below set, standing in for the probe at i = -1; this makes every
  // key cost exactly shifts+1 SCAN cycles.
  always_comb begin
    w_next_state = r_state;
    w_do_clear   = 1'b0;
    w_do_push    = 1'b0;
    w_do_pop     = 1'b0;
    w_do_sort    = 1'b0;
    w_we         = 1'b0;
    w_waddr      = '0;
    w_wdata      = '0;
    case (r_state)
      IDLE: begin
        if (clear) begin
          w_do_clear = 1'b1;
        end else if (push) begin
          w_do_push = 1'b1;
          w_we      = !w_full;
          w_waddr   = r_count[AW-1:0];
          w_wdata   = din;
        end else if (pop) begin
          w_do_pop = 1'b1;
        end else if (sort) begin
          w_do_sort    = 1'b1;
          w_next_state = (r_count < CNT_TWO) ? DONE : J_LOAD;
        end
      end
      J_LOAD: w_next_state = SCAN;
      SCAN: begin
        if (r_below) begin
          w_next_state = WRITE;
        end else if (w_before) begin
          w_we    = 1'b1;
          w_waddr = w_shift_idx;
          w_wdata = w_i_word;
        end else begin
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        w_we         = 1'b1;
        w_waddr      = r_below ? IDX_ZERO : w_shift_idx;
        w_wdata      = r_key;
        w_next_state = w_last_j ? DONE : J_LOAD;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Occupancy, pop data, sort indices and the registered status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count      <= '0;
      r_j          <= '0;
      r_i          <= '0;
      r_key        <= '0;
      r_dir        <= 1'b0;
      r_below      <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else if (enable) begin
      r_dout_valid <= 1'b0;
      r_err        <= 1'b0;
      r_done       <= (w_next_state == DONE);
      if (w_do_clear) begin
        r_count <= '0;
      end else if (w_do_push) begin
        if (w_full) r_err <= 1'b1;
        else        r_count <= r_count + CNT_ONE;
      end else if (w_do_pop) begin
        if (w_empty) begin
          r_err <= 1'b1;
        end else begin
          r_dout       <= w_top_word;
          r_dout_valid <= 1'b1;
          r_count      <= r_count - CNT_ONE;
        end
      end else if (w_do_sort) begin
        r_dir <= descend;
        r_j   <= IDX_ONE;
      end
      case (r_state)
        J_LOAD: begin
          r_key   <= w_j_word;
          r_i     <= r_j - IDX_ONE;
          r_below <= 1'b0;
        end
        SCAN: begin
          if (!r_below && w_before) begin
            if (r_i == IDX_ZERO) r_below <= 1'b1;
            else                 r_i     <= r_i - IDX_ONE;
          end
        end
        WRITE:   r_j <= r_j + IDX_ONE;
        default: ;
      endcase
    end
  end

  // Storage has no reset; its contents are undefined after rstn.
  always_ff @(posedge clk) begin
    if (enable && w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign idle       = (r_state == IDLE);
  assign done       = r_done;
  assign err        = r_err;

endmodule
